// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: data width, canonical NOP and the fetch FSM encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

  typedef enum logic {
    FETCH_RUN   = 1'b0,
    FETCH_FAULT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Squash inserts a bubble (valid=0, NOP) while
// keeping the PC; hold freezes everything; otherwise it loads a new fetch.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            squash,
  input  logic            hold,
  input  logic [XLEN-1:0] d_instr,
  input  logic [XLEN-1:0] d_pc,
  output logic            q_valid,
  output logic [XLEN-1:0] q_instr,
  output logic [XLEN-1:0] q_pc
);

  // Squash wins over hold so a redirect during a stall still bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_instr <= RV_NOP;
      q_pc    <= '0;
    end else if (squash) begin
      q_valid <= 1'b0;
      q_instr <= RV_NOP;
    end else if (!hold) begin
      q_valid <= 1'b1;
      q_instr <= d_instr;
      q_pc    <= d_pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: PC register, next-PC selection, bounds and
// alignment check, and a terminal FAULT state cleared only by reset.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              N        = 9,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [N-1:0]    imem_addr,
  input  logic [XLEN-1:0] imem_rd,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic            fetch_fault,
  output logic [XLEN-1:0] fault_pc,
  output fetch_state_e    fsm_state
);

  logic [XLEN-1:0] pc;
  fetch_state_e    state;
  logic            pc_ok;
  logic            squash;
  logic            hold;

  // A word at pc is fully inside memory only if aligned and below 2^N.
  assign pc_ok     = (pc[1:0] == 2'b00) && ((pc >> N) == '0);
  assign imem_addr = pc[N-1:0];
  assign fsm_state = state;

  assign squash = (state == FETCH_FAULT) || redirect_valid || (!stall && !pc_ok);
  assign hold   = stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      state       <= FETCH_RUN;
      fetch_fault <= 1'b0;
      fault_pc    <= '0;
    end else begin
      case (state)
        FETCH_RUN: begin
          if (redirect_valid) begin
            pc <= redirect_target;
          end else if (stall) begin
            pc <= pc;
          end else if (!pc_ok) begin
            state       <= FETCH_FAULT;
            fetch_fault <= 1'b1;
            fault_pc    <= pc;
          end else begin
            pc <= pc + 32'd4;
          end
        end
        default: begin
          state <= FETCH_FAULT;
        end
      endcase
    end
  end

  if_id_reg u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .squash  (squash),
    .hold    (hold),
    .d_instr (imem_rd),
    .d_pc    (pc),
    .q_valid (if_valid),
    .q_instr (if_instr),
    .q_pc    (if_pc)
  );

  assign if_pc_plus4 = if_pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a big-endian byte-array instruction memory.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam int N = 9;
  localparam logic [31:0] W0 = 32'h0050_0093;
  localparam logic [31:0] W1 = 32'h00A0_0113;
  localparam logic [31:0] W2 = 32'h0020_81B3;
  localparam logic [31:0] W3 = 32'h4011_0233;
  localparam logic [31:0] W40 = 32'hDEAD_BEEF;
  localparam logic [31:0] W1FC = 32'h0000_006F;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         stall;
  logic         redirect_valid;
  logic [31:0]  redirect_target;
  logic [N-1:0] imem_addr;
  logic [31:0]  imem_rd;
  logic         if_valid;
  logic [31:0]  if_instr;
  logic [31:0]  if_pc;
  logic [31:0]  if_pc_plus4;
  logic         fetch_fault;
  logic [31:0]  fault_pc;
  fetch_state_e fsm_state;

  logic [7:0] mem [0:(1<<N)-1];

  int compared = 0;
  int mismatched = 0;

  // clock / reset block
  always #5 clk = ~clk;

  fetch_unit #(.N(N), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_rd         (imem_rd),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4),
    .fetch_fault     (fetch_fault),
    .fault_pc        (fault_pc),
    .fsm_state       (fsm_state)
  );

  // Combinational big-endian memory model
  always_comb begin
    logic [N-1:0] a1, a2, a3;
    a1 = imem_addr + 9'd1;
    a2 = imem_addr + 9'd2;
    a3 = imem_addr + 9'd3;
    imem_rd = {mem[imem_addr], mem[a1], mem[a2], mem[a3]};
  end

  task automatic put_word(input int addr, input logic [31:0] w);
    mem[addr]   = w[31:24];
    mem[addr+1] = w[23:16];
    mem[addr+2] = w[15:8];
    mem[addr+3] = w[7:0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_slot(input string tag, input logic v, input logic [31:0] ins,
                            input logic [31:0] pc);
    check({tag, ".valid"}, {31'd0, if_valid}, {31'd0, v});
    check({tag, ".instr"}, if_instr, ins);
    check({tag, ".pc"}, if_pc, pc);
    check({tag, ".pc4"}, if_pc_plus4, pc + 32'd4);
  endtask

  initial begin
    for (int a = 0; a < (1 << N); a += 4) put_word(a, 32'hC000_0000 | a);
    put_word(32'h000, W0);
    put_word(32'h004, W1);
    put_word(32'h008, W2);
    put_word(32'h00C, W3);
    put_word(32'h040, W40);
    put_word(32'h1FC, W1FC);

    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    step(); step();
    check_slot("reset", 1'b0, NOP, 32'h0);
    check("reset.fault", {31'd0, fetch_fault}, 32'd0);
    check("reset.fault_pc", fault_pc, 32'h0);
    check("reset.addr", {23'd0, imem_addr}, 32'h0);
    check("reset.state", {31'd0, fsm_state}, {31'd0, FETCH_RUN});

    // Free run 0,4,8,C
    rst_n = 1'b1;
    step(); check_slot("run0", 1'b1, W0, 32'h0);
    step(); check_slot("run4", 1'b1, W1, 32'h4);
    step(); check_slot("run8", 1'b1, W2, 32'h8);
    step(); check_slot("runC", 1'b1, W3, 32'hC);
    check("runC.addr", {23'd0, imem_addr}, 32'h10);

    // Back to 0, then stall at if_pc=4
    redirect_valid = 1'b1; redirect_target = 32'h0;
    step(); check_slot("rd0.bubble", 1'b0, NOP, 32'hC);
    redirect_valid = 1'b0;
    step(); check_slot("rd0.w0", 1'b1, W0, 32'h0);
    step(); check_slot("rd0.w1", 1'b1, W1, 32'h4);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check_slot("stall", 1'b1, W1, 32'h4);
      check("stall.addr", {23'd0, imem_addr}, 32'h8);
    end
    stall = 1'b0;
    step(); check_slot("unstall", 1'b1, W2, 32'h8);

    // Redirect to 0x40 together with stall
    redirect_valid = 1'b1; redirect_target = 32'h40; stall = 1'b1;
    step(); check_slot("rd40.bubble", 1'b0, NOP, 32'h8);
    check("rd40.addr", {23'd0, imem_addr}, 32'h40);
    redirect_valid = 1'b0; stall = 1'b0;
    step(); check_slot("rd40.hit", 1'b1, W40, 32'h40);

    // Misaligned redirect faults on the next fetch attempt
    redirect_valid = 1'b1; redirect_target = 32'h42;
    step(); check_slot("rd42.bubble", 1'b0, NOP, 32'h40);
    check("rd42.nofault", {31'd0, fetch_fault}, 32'd0);
    redirect_valid = 1'b0;
    step();
    check("rd42.fault", {31'd0, fetch_fault}, 32'd1);
    check("rd42.fault_pc", fault_pc, 32'h42);
    check("rd42.valid", {31'd0, if_valid}, 32'd0);
    check("rd42.state", {31'd0, fsm_state}, {31'd0, FETCH_FAULT});
    redirect_valid = 1'b1; redirect_target = 32'h0; stall = 1'b1;
    step(); step();
    check("fault.ignore.addr", {23'd0, imem_addr}, 32'h042);
    check_slot("fault.ignore", 1'b0, NOP, 32'h40);
    check("fault.ignore.flag", {31'd0, fetch_fault}, 32'd1);
    check("fault.ignore.fpc", fault_pc, 32'h42);

    // One-cycle reset clears the fault and fetching resumes
    redirect_valid = 1'b0; stall = 1'b0; rst_n = 1'b0;
    step();
    check("rst.fault", {31'd0, fetch_fault}, 32'd0);
    check("rst.fault_pc", fault_pc, 32'h0);
    check("rst.addr", {23'd0, imem_addr}, 32'h0);
    check_slot("rst", 1'b0, NOP, 32'h0);
    rst_n = 1'b1;
    step(); check_slot("rst.w0", 1'b1, W0, 32'h0);

    // Run off the top of the 512-byte memory
    redirect_valid = 1'b1; redirect_target = 32'h1F8;
    step(); check_slot("top.bubble", 1'b0, NOP, 32'h0);
    redirect_valid = 1'b0;
    step(); check_slot("top.1f8", 1'b1, 32'hC000_01F8, 32'h1F8);
    step(); check_slot("top.1fc", 1'b1, W1FC, 32'h1FC);
    check("top.fault_early", {31'd0, fetch_fault}, 32'd0);
    step();
    check("top.fault", {31'd0, fetch_fault}, 32'd1);
    check("top.fault_pc", fault_pc, 32'h200);
    check_slot("top.after", 1'b0, NOP, 32'h1FC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
